// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: opcode encodings, default widths and width helpers.
package tl_pkg;

  localparam int unsigned TL_NUM_MASTERS = 2;
  localparam int unsigned TL_ADDR_W      = 32;
  localparam int unsigned TL_DATA_W      = 32;
  localparam int unsigned TL_SIZE_W      = 3;
  localparam int unsigned TL_SRC_W       = 1;
  localparam int unsigned TL_SINK_W      = 1;
  localparam int unsigned TL_OPCODE_W    = 3;
  localparam int unsigned TL_PARAM_W     = 3;
  localparam int unsigned TL_MAX_OUT     = 4;

  typedef enum logic [2:0] {
    TL_A_PUT_FULL    = 3'd0,
    TL_A_PUT_PARTIAL = 3'd1,
    TL_A_GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    TL_D_ACCESS_ACK      = 3'd0,
    TL_D_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  // Master-index field width; a single master still carries one (zero) bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the pointer
// moves just past the winner whenever the grant is consumed.
module tl_rr_arbiter
  import tl_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin : p_pick
    int unsigned m;
    logic        found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    m           = 0;
    for (int unsigned k = 0; k < N; k++) begin
      m = 32'(ptr_q) + k;
      if (m >= N) m = m - N;
      if (!found && req_i[IW'(m)]) begin
        grant_o[IW'(m)] = 1'b1;
        grant_idx_o     = IW'(m);
        found           = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tl_xbar_nm1s.sv
// N-master to 1-slave TileLink-UL crossbar: round-robin A arbitration into a one-entry
// registered slice, D demux by source index, per-master outstanding limits.
module tl_xbar_nm1s
  import tl_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS     = TL_NUM_MASTERS,
  parameter  int unsigned ADDR_WIDTH      = TL_ADDR_W,
  parameter  int unsigned DATA_WIDTH      = TL_DATA_W,
  parameter  int unsigned MASK_WIDTH      = DATA_WIDTH / 8,
  parameter  int unsigned SIZE_WIDTH      = TL_SIZE_W,
  parameter  int unsigned SRC_WIDTH       = TL_SRC_W,
  parameter  int unsigned SINK_WIDTH      = TL_SINK_W,
  parameter  int unsigned OPCODE_WIDTH    = TL_OPCODE_W,
  parameter  int unsigned PARAM_WIDTH     = TL_PARAM_W,
  parameter  int unsigned MAX_OUTSTANDING = TL_MAX_OUT,
  localparam int unsigned IDX_WIDTH       = idx_width(NUM_MASTERS),
  localparam int unsigned OSRC_WIDTH      = SRC_WIDTH + IDX_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  // master-side A
  input  logic [NUM_MASTERS-1:0]             a_valid,
  output logic [NUM_MASTERS-1:0]             a_ready,
  input  logic [NUM_MASTERS*OPCODE_WIDTH-1:0] a_opcode,
  input  logic [NUM_MASTERS*PARAM_WIDTH-1:0] a_param,
  input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]  a_size,
  input  logic [NUM_MASTERS*SRC_WIDTH-1:0]   a_source,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  a_address,
  input  logic [NUM_MASTERS*MASK_WIDTH-1:0]  a_mask,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  a_data,
  // master-side D
  output logic [NUM_MASTERS-1:0]             d_valid,
  input  logic [NUM_MASTERS-1:0]             d_ready,
  output logic [NUM_MASTERS*OPCODE_WIDTH-1:0] d_opcode,
  output logic [NUM_MASTERS*PARAM_WIDTH-1:0] d_param,
  output logic [NUM_MASTERS*SIZE_WIDTH-1:0]  d_size,
  output logic [NUM_MASTERS*SRC_WIDTH-1:0]   d_source,
  output logic [NUM_MASTERS*SINK_WIDTH-1:0]  d_sink,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]  d_data,
  output logic [NUM_MASTERS-1:0]             d_error,
  // slave-side A
  output logic                               a_valid_out,
  input  logic                               a_ready_out,
  output logic [OPCODE_WIDTH-1:0]            a_opcode_out,
  output logic [PARAM_WIDTH-1:0]             a_param_out,
  output logic [SIZE_WIDTH-1:0]              a_size_out,
  output logic [OSRC_WIDTH-1:0]              a_source_out,
  output logic [ADDR_WIDTH-1:0]              a_address_out,
  output logic [MASK_WIDTH-1:0]              a_mask_out,
  output logic [DATA_WIDTH-1:0]              a_data_out,
  // slave-side D
  input  logic                               d_valid_in,
  output logic                               d_ready_in,
  input  logic [OPCODE_WIDTH-1:0]            d_opcode_in,
  input  logic [PARAM_WIDTH-1:0]             d_param_in,
  input  logic [SIZE_WIDTH-1:0]              d_size_in,
  input  logic [OSRC_WIDTH-1:0]              d_source_in,
  input  logic [SINK_WIDTH-1:0]              d_sink_in,
  input  logic [DATA_WIDTH-1:0]              d_data_in,
  input  logic                               d_error_in,
  output logic                               decode_err
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [PARAM_WIDTH-1:0]  param;
    logic [SIZE_WIDTH-1:0]   size;
    logic [OSRC_WIDTH-1:0]   source;
    logic [ADDR_WIDTH-1:0]   address;
    logic [MASK_WIDTH-1:0]   mask;
    logic [DATA_WIDTH-1:0]   data;
  } a_beat_t;

  logic                   slot_free;
  logic                   advance;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDX_WIDTH-1:0]   grant_idx;
  a_beat_t                sel_beat;
  a_beat_t                slice_q, slice_d;
  logic                   a_valid_q, a_valid_d;
  logic [IDX_WIDTH-1:0]   d_idx;
  logic                   d_idx_ok;
  logic                   d_ready_sel;
  logic                   decode_err_q, decode_err_d;

  assign slot_free = !a_valid_q || a_ready_out;
  assign advance   = slot_free && (|eligible) && !reset;
  assign a_ready   = (slot_free && !reset) ? grant : '0;

  tl_rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_i      (eligible),
    .advance_i  (advance),
    .grant_o    (grant),
    .grant_idx_o(grant_idx)
  );

  // One-hot payload mux; the slave-side source is tagged with the winner index.
  always_comb begin
    sel_beat = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        sel_beat.opcode  = a_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH];
        sel_beat.param   = a_param[i*PARAM_WIDTH +: PARAM_WIDTH];
        sel_beat.size    = a_size[i*SIZE_WIDTH +: SIZE_WIDTH];
        sel_beat.source  = {grant_idx, a_source[i*SRC_WIDTH +: SRC_WIDTH]};
        sel_beat.address = a_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_beat.mask    = a_mask[i*MASK_WIDTH +: MASK_WIDTH];
        sel_beat.data    = a_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    a_valid_d = a_valid_q;
    slice_d   = slice_q;
    if (slot_free) begin
      a_valid_d = |grant;
      if (|grant) slice_d = sel_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      slice_q   <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      slice_q   <= slice_d;
    end
  end

  assign a_valid_out   = a_valid_q;
  assign a_opcode_out  = slice_q.opcode;
  assign a_param_out   = slice_q.param;
  assign a_size_out    = slice_q.size;
  assign a_source_out  = slice_q.source;
  assign a_address_out = slice_q.address;
  assign a_mask_out    = slice_q.mask;
  assign a_data_out    = slice_q.data;

  // D demux: indices beyond the master count are sunk and flagged.
  assign d_idx    = d_source_in[OSRC_WIDTH-1:SRC_WIDTH];
  assign d_idx_ok = 32'(d_idx) < 32'(NUM_MASTERS);

  always_comb begin
    d_ready_sel = 1'b1;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (d_idx == IDX_WIDTH'(j)) d_ready_sel = d_ready[j];
    end
  end

  assign d_ready_in   = d_ready_sel && !reset;
  assign decode_err_d = d_valid_in && !d_idx_ok;

  always_ff @(posedge clk) begin
    if (reset) decode_err_q <= 1'b0;
    else       decode_err_q <= decode_err_d;
  end

  assign decode_err = decode_err_q;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
    logic                 a_hs, d_hs;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign d_valid[g] = d_valid_in && (d_idx == IDX_WIDTH'(g)) && !reset;
    assign d_opcode[g*OPCODE_WIDTH +: OPCODE_WIDTH] = d_opcode_in;
    assign d_param[g*PARAM_WIDTH +: PARAM_WIDTH]    = d_param_in;
    assign d_size[g*SIZE_WIDTH +: SIZE_WIDTH]       = d_size_in;
    assign d_source[g*SRC_WIDTH +: SRC_WIDTH]       = d_source_in[SRC_WIDTH-1:0];
    assign d_sink[g*SINK_WIDTH +: SINK_WIDTH]       = d_sink_in;
    assign d_data[g*DATA_WIDTH +: DATA_WIDTH]       = d_data_in;
    assign d_error[g]                               = d_error_in;

    assign a_hs        = a_valid[g] && a_ready[g];
    assign d_hs        = d_valid[g] && d_ready[g];
    assign eligible[g] = a_valid[g] && (cnt_q < CNT_WIDTH'(MAX_OUTSTANDING));

    // Responses never bypass the limit within the same cycle; decrement saturates at 0.
    always_comb begin
      cnt_d = cnt_q;
      if (a_hs && !d_hs)                        cnt_d = cnt_q + CNT_WIDTH'(1);
      else if (!a_hs && d_hs && cnt_q != '0)    cnt_d = cnt_q - CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(d_hs && cnt_q == '0));
  end

endmodule

// File: tb/tb_tl_xbar_nm1s.sv
// Bench for tl_xbar_nm1s (3 masters, limit 2): directed scenarios plus random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_tl_xbar_nm1s;
  import tl_pkg::*;

  localparam int N   = 3;
  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  a_valid, a_ready;
  logic [8:0]  a_opcode, a_param, a_size;
  logic [2:0]  a_source;
  logic [95:0] a_address, a_data;
  logic [11:0] a_mask;
  logic [2:0]  d_valid, d_ready;
  logic [8:0]  d_opcode, d_param, d_size;
  logic [2:0]  d_source, d_sink;
  logic [95:0] d_data;
  logic [2:0]  d_error;
  logic        a_valid_out, a_ready_out;
  logic [2:0]  a_opcode_out, a_param_out, a_size_out, a_source_out;
  logic [31:0] a_address_out, a_data_out;
  logic [3:0]  a_mask_out;
  logic        d_valid_in, d_ready_in;
  logic [2:0]  d_opcode_in, d_param_in, d_size_in, d_source_in;
  logic [0:0]  d_sink_in;
  logic [31:0] d_data_in;
  logic        d_error_in, decode_err;

  // per-master stimulus payloads
  logic [2:0]  t_op [N];
  logic [2:0]  t_par[N];
  logic [2:0]  t_sz [N];
  logic        t_src[N];
  logic [31:0] t_adr[N];
  logic [3:0]  t_msk[N];
  logic [31:0] t_dat[N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign a_opcode[g*3 +: 3]   = t_op[g];
    assign a_param[g*3 +: 3]    = t_par[g];
    assign a_size[g*3 +: 3]     = t_sz[g];
    assign a_source[g]          = t_src[g];
    assign a_address[g*32 +: 32] = t_adr[g];
    assign a_mask[g*4 +: 4]     = t_msk[g];
    assign a_data[g*32 +: 32]   = t_dat[g];
  end

  always #5 clk = ~clk;

  tl_xbar_nm1s #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data), .d_error(d_error),
    .a_valid_out(a_valid_out), .a_ready_out(a_ready_out), .a_opcode_out(a_opcode_out),
    .a_param_out(a_param_out), .a_size_out(a_size_out), .a_source_out(a_source_out),
    .a_address_out(a_address_out), .a_mask_out(a_mask_out), .a_data_out(a_data_out),
    .d_valid_in(d_valid_in), .d_ready_in(d_ready_in), .d_opcode_in(d_opcode_in),
    .d_param_in(d_param_in), .d_size_in(d_size_in), .d_source_in(d_source_in),
    .d_sink_in(d_sink_in), .d_data_in(d_data_in), .d_error_in(d_error_in),
    .decode_err(decode_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int          m_cnt[N];
  int          m_ptr;
  bit          m_v;
  bit          m_derr;
  logic [2:0]  m_op, m_src;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_msk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = 0; m_v = 0; m_derr = 0;
    m_op = '0; m_src = '0; m_adr = '0; m_dat = '0; m_msk = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    int         w, idx, m;
    bit         sf;
    logic [2:0] e_ar, e_dv;
    #1;
    sf = !m_v || a_ready_out;
    w  = -1;
    for (int k = 0; k < N; k++) begin
      m = (m_ptr + k) % N;
      if (w < 0 && a_valid[2'(m)] && m_cnt[m] < MAX) w = m;
    end
    idx  = int'(d_source_in[2:1]);
    e_ar = (!reset && sf && w >= 0) ? 3'(1 << w) : 3'b000;
    e_dv = (!reset && d_valid_in && idx < N) ? 3'(1 << idx) : 3'b000;
    chk("a_ready", 64'(a_ready), 64'(e_ar));
    chk("d_valid", 64'(d_valid), 64'(e_dv));
    if (!reset) chk("d_ready_in", 64'(d_ready_in), (idx < N) ? 64'(d_ready[2'(idx)]) : 64'd1);
    chk("d_source1", 64'(d_source[1]), 64'(d_source_in[0]));
    chk("d_data1", 64'(d_data[63:32]), 64'(d_data_in));
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (e_dv != 0 && d_ready[2'(idx)] && m_cnt[idx] > 0) m_cnt[idx]--;
      if (sf) begin
        m_v = (w >= 0);
        if (w >= 0) begin
          m_op = t_op[w]; m_adr = t_adr[w]; m_dat = t_dat[w]; m_msk = t_msk[w];
          m_src = {2'(w), t_src[w]};
          m_cnt[w]++;
          m_ptr = (w + 1) % N;
        end
      end
      m_derr = d_valid_in && (idx >= N);
    end
    #1;
    chk("a_valid_out", 64'(a_valid_out), 64'(m_v));
    chk("a_source_out", 64'(a_source_out), 64'(m_src));
    chk("a_address_out", 64'(a_address_out), 64'(m_adr));
    chk("a_data_out", 64'(a_data_out), 64'(m_dat));
    chk("a_opcode_out", 64'(a_opcode_out), 64'(m_op));
    chk("a_mask_out", 64'(a_mask_out), 64'(m_msk));
    chk("decode_err", 64'(decode_err), 64'(m_derr));
  endtask

  task automatic d_beat(input logic [2:0] src, input logic [2:0] rdy);
    d_valid_in = 1'b1; d_source_in = src; d_ready = rdy;
    step();
    d_valid_in = 1'b0; d_ready = '0;
  endtask

  initial begin
    reset = 1'b1; a_valid = '0; a_ready_out = 1'b0; d_ready = '0;
    d_valid_in = 1'b0; d_opcode_in = '0; d_param_in = '0; d_size_in = '0;
    d_source_in = '0; d_sink_in = '0; d_data_in = '0; d_error_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      t_op[i] = TL_A_GET; t_par[i] = '0; t_sz[i] = 3'd2; t_src[i] = 1'b0;
      t_adr[i] = 32'(i) << 8; t_msk[i] = 4'hf; t_dat[i] = 32'(i);
    end
    model_clear();

    // reset holds everything quiet even with traffic presented
    a_valid = 3'b111; a_ready_out = 1'b1; d_valid_in = 1'b1;
    step(); step();
    chk("rst_a_valid_out", 64'(a_valid_out), 64'd0);
    reset = 1'b0; a_valid = '0; d_valid_in = 1'b0;

    // M0 and M1 both requesting: grants alternate, source tagged with index
    a_valid = 3'b011;
    step(); chk("alt0_src", 64'(a_source_out), 64'(3'b000));
    step(); chk("alt1_src", 64'(a_source_out), 64'(3'b010));
    step(); chk("alt2_src", 64'(a_source_out), 64'(3'b000));
    a_valid = '0;
    d_beat(3'b000, 3'b001); d_beat(3'b000, 3'b001); d_beat(3'b010, 3'b010);
    step();

    // Get from M0 stalled by the slave for three cycles
    a_valid = 3'b001; t_op[0] = TL_A_GET; t_adr[0] = 32'h0000_1000;
    step();
    a_ready_out = 1'b0; a_valid = 3'b011; t_adr[0] = 32'h0000_2000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_addr", 64'(a_address_out), 64'h1000);
      chk("stall_opcode", 64'(a_opcode_out), 64'(TL_A_GET));
      chk("stall_ready", 64'(a_ready), 64'd0);
    end
    a_ready_out = 1'b1;
    #1 chk("release_ready", 64'(a_ready), 64'(3'b010));
    step();
    a_valid = '0;
    d_beat(3'b000, 3'b001); d_beat(3'b010, 3'b010);
    step();

    // M1 hits its outstanding limit; a response re-enables it one cycle later
    a_valid = 3'b010;
    step(); step();
    #1 chk("limit_block", 64'(a_ready), 64'd0);
    d_valid_in = 1'b1; d_source_in = 3'b010; d_ready = 3'b010;
    #1 chk("no_bypass", 64'(a_ready), 64'd0);
    step();
    d_valid_in = 1'b0; d_ready = '0;
    #1 chk("regrant", 64'(a_ready), 64'(3'b010));
    step();
    a_valid = '0;

    // D routing to M1 with backpressure
    d_valid_in = 1'b1; d_source_in = 3'b011; d_data_in = 32'hDEAD_BEEF; d_ready = 3'b000;
    #1;
    chk("route_valid", 64'(d_valid), 64'(3'b010));
    chk("route_src", 64'(d_source[1]), 64'd1);
    chk("route_data", 64'(d_data[63:32]), 64'hDEAD_BEEF);
    chk("route_ready_lo", 64'(d_ready_in), 64'd0);
    step();
    d_ready = 3'b010;
    #1 chk("route_ready_hi", 64'(d_ready_in), 64'd1);
    step();
    d_beat(3'b010, 3'b010);

    // out-of-range index is sunk with a single decode_err pulse
    d_valid_in = 1'b1; d_source_in = 3'b110; d_ready = '0;
    #1;
    chk("dec_valid", 64'(d_valid), 64'd0);
    chk("dec_ready", 64'(d_ready_in), 64'd1);
    step();
    chk("dec_pulse", 64'(decode_err), 64'd1);
    d_valid_in = 1'b0;
    step();
    chk("dec_clear", 64'(decode_err), 64'd0);

    // reset while the slice holds a beat and counters are nonzero
    a_valid = 3'b011; a_ready_out = 1'b1;
    step();
    a_ready_out = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rst_mid_valid", 64'(a_valid_out), 64'd0);
    reset = 1'b0; a_ready_out = 1'b1;
    #1 chk("rst_ptr", 64'(a_ready), 64'(3'b001));
    step();

    // random traffic; responses only ever target masters with requests in flight
    for (int c = 0; c < 400; c++) begin
      int r, st, pick;
      reset = ($urandom_range(0, 99) == 0);
      a_valid = 3'($urandom);
      a_ready_out = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        t_op[i] = 3'($urandom); t_par[i] = 3'($urandom); t_sz[i] = 3'($urandom);
        t_src[i] = 1'($urandom); t_adr[i] = $urandom; t_msk[i] = 4'($urandom);
        t_dat[i] = $urandom;
      end
      d_opcode_in = 3'($urandom); d_param_in = 3'($urandom); d_size_in = 3'($urandom);
      d_sink_in = 1'($urandom); d_data_in = $urandom; d_error_in = 1'($urandom);
      d_ready = 3'($urandom);
      d_valid_in = 1'b0;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        d_valid_in = 1'b1; d_source_in = {2'd3, 1'($urandom)};
      end else if (r < 6) begin
        st = int'($urandom_range(0, N - 1));
        pick = -1;
        for (int k = 0; k < N; k++)
          if (pick < 0 && m_cnt[(st + k) % N] > 0) pick = (st + k) % N;
        if (pick >= 0) begin
          d_valid_in = 1'b1; d_source_in = {2'(pick), 1'($urandom)};
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
